rasterizer_mem_arbiter: RTL and testbench

Shares the single SDRAM Avalon-MM master port between up to `NUM_REQ` rasterizer requesters: depth fetch, depth/color writeback and frame-clear. Each requester gets an Avalon-MM-style slave port. Read data is routed back to the issuing requester through an in-order tag FIFO. The block sits between the rasterizer pipeline stages and the SDRAM controller bus interface.

---
 rtl/rasterizer_pkg.sv | 13 +
 rtl/rasterizer_mem_arbiter_if.sv | 39 +++
 rtl/arb_tag_fifo.sv | 55 +++++
 rtl/rasterizer_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rasterizer_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the rasterizer SDRAM arbiter.
package rasterizer_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_t;

    // Wide enough to index up to four requesters.
    localparam int REQ_IDX_W               = 2;
    localparam int MAX_OUTSTANDING_DEFAULT = 16;

endpackage

// File: rtl/rasterizer_mem_arbiter_if.sv
// Requester-side slave ports plus the SDRAM master port, bundled for the arbiter.
interface rasterizer_mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 26
);
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]             req_read;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][3:0]        req_byteenable;
    logic [NUM_REQ-1:0][31:0]       req_writedata;
    logic [NUM_REQ-1:0]             req_waitrequest;
    logic [NUM_REQ-1:0]             req_readdatavalid;
    logic [31:0]                    req_readdata;

    logic [ADDR_W-1:0]              master_address;
    logic                           master_read;
    logic                           master_write;
    logic [3:0]                     master_byteenable;
    logic [31:0]                    master_writedata;
    logic [31:0]                    master_readdata;
    logic                           master_readdatavalid;
    logic                           master_waitrequest;

    // Arbiter view.
    modport slave (
        input  req_address, req_read, req_write, req_byteenable, req_writedata,
        input  master_readdata, master_readdatavalid, master_waitrequest,
        output req_waitrequest, req_readdatavalid, req_readdata,
        output master_address, master_read, master_write, master_byteenable, master_writedata
    );

    // Environment view: requesters plus SDRAM controller.
    modport master (
        output req_address, req_read, req_write, req_byteenable, req_writedata,
        output master_readdata, master_readdatavalid, master_waitrequest,
        input  req_waitrequest, req_readdatavalid, req_readdata,
        input  master_address, master_read, master_write, master_byteenable, master_writedata
    );
endinterface

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding read.
module arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A pop frees its slot first, so a full FIFO still accepts a simultaneous push.
    assign do_pop_s  = pop & (count_r != {CW{1'b0}});
    assign do_push_s = push & ((count_r != CW'(DEPTH)) | do_pop_s);
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage.
    always_ff @(posedge clock) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end
endmodule

// File: rtl/rasterizer_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master among rasterizer requesters.
// Define RASTER_ARB_FIXED_PRIO_EN to give port 0 (writeback) absolute priority.
module rasterizer_mem_arbiter
    import rasterizer_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_W          = 26,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                             clock,
    input  logic                             reset,
    rasterizer_mem_arbiter_if.slave          bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_orphan
);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t             state_r, state_nxt_s;
    logic [REQ_IDX_W-1:0]   grant_r, grant_nxt_s;
    logic [REQ_IDX_W-1:0]   last_grant_r, last_grant_nxt_s;
    logic [REQ_IDX_W:0]     pick_s;
    logic [NUM_REQ-1:0]     elig_s;
    logic                   fifo_full_s, fifo_empty_s, full_eff_s;
    logic [REQ_IDX_W-1:0]   fifo_head_s;
    logic                   push_s, pop_s;
    logic                   owner_rd_s, owner_wr_s, owner_req_s, fwd_s, accept_s;
    logic [NUM_REQ-1:0]     rdv_r;
    logic [31:0]            rdata_r;
    logic                   err_r;

    // Returns {found, index}: first eligible port strictly after 'last' in ring order.
    function automatic logic [REQ_IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                   input logic [REQ_IDX_W-1:0] last);
        logic [REQ_IDX_W:0] res;
        int                 c;
        res = {(REQ_IDX_W+1){1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = (int'(last) + k) % NUM_REQ;
            if (elig[c]) res = {1'b1, REQ_IDX_W'(c)};
        end
        return res;
    endfunction

    function automatic logic [REQ_IDX_W:0] arb_pick(input logic [NUM_REQ-1:0] elig,
                                                    input logic [REQ_IDX_W-1:0] last);
`ifdef RASTER_ARB_FIXED_PRIO_EN
        if (elig[0]) return {1'b1, {REQ_IDX_W{1'b0}}};
        else         return rr_pick(elig & ~ONE_HOT0, last);
`else
        return rr_pick(elig, last);
`endif
    endfunction

    arb_tag_fifo #(.WIDTH(REQ_IDX_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (grant_r),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (outstanding)
    );

    // Eligibility and forwarding; a same-cycle return makes room for a read.
    always_comb begin
        pop_s      = bus.master_readdatavalid & ~fifo_empty_s;
        full_eff_s = fifo_full_s & ~pop_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i] = (bus.req_read[i] | bus.req_write[i]) &
                        ~(bus.req_read[i] & ~bus.req_write[i] & full_eff_s);
        end
        owner_rd_s  = bus.req_read[grant_r];
        owner_wr_s  = bus.req_write[grant_r];
        owner_req_s = owner_rd_s | owner_wr_s;
        fwd_s       = (state_r == S_GRANT) & owner_req_s & ~(owner_rd_s & full_eff_s);
        accept_s    = fwd_s & ~bus.master_waitrequest;
        push_s      = accept_s & owner_rd_s;
    end

    // Next grant / state selection.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        pick_s           = {(REQ_IDX_W+1){1'b0}};
        case (state_r)
            S_IDLE: begin
                pick_s = arb_pick(elig_s, last_grant_r);
                if (pick_s[REQ_IDX_W]) begin
                    grant_nxt_s = pick_s[REQ_IDX_W-1:0];
                    state_nxt_s = S_GRANT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_GRANT: begin
                if (accept_s) begin
                    last_grant_nxt_s = grant_r;
                    pick_s = arb_pick(elig_s & ~(ONE_HOT0 << grant_r), grant_r);
                    if (pick_s[REQ_IDX_W]) begin
                        grant_nxt_s = pick_s[REQ_IDX_W-1:0];
                        state_nxt_s = S_GRANT;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else if (!owner_req_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_GRANT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Command mux toward SDRAM and per-port stall.
    always_comb begin
        bus.master_address    = {ADDR_W{1'b0}};
        bus.master_byteenable = 4'h0;
        bus.master_writedata  = 32'h0;
        bus.master_read       = 1'b0;
        bus.master_write      = 1'b0;
        bus.req_waitrequest   = {NUM_REQ{1'b1}};
        if (state_r == S_GRANT) begin
            bus.master_address    = bus.req_address[grant_r];
            bus.master_byteenable = bus.req_byteenable[grant_r];
            bus.master_writedata  = bus.req_writedata[grant_r];
            bus.master_read       = fwd_s & owner_rd_s;
            bus.master_write      = fwd_s & ~owner_rd_s & owner_wr_s;
            bus.req_waitrequest[grant_r] = fwd_s ? bus.master_waitrequest : 1'b1;
        end else begin
            bus.master_read       = 1'b0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            grant_r      <= {REQ_IDX_W{1'b0}};
            last_grant_r <= REQ_IDX_W'(NUM_REQ - 1);
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Registered read return routing and sticky orphan flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdv_r   <= {NUM_REQ{1'b0}};
            rdata_r <= 32'h0;
            err_r   <= 1'b0;
        end else begin
            rdv_r <= {NUM_REQ{1'b0}};
            if (bus.master_readdatavalid) begin
                if (!fifo_empty_s) begin
                    rdv_r   <= ONE_HOT0 << fifo_head_s;
                    rdata_r <= bus.master_readdata;
                end else begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.req_readdatavalid = rdv_r;
    assign bus.req_readdata      = rdata_r;
    assign err_orphan            = err_r;
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Randomized and directed bench for rasterizer_mem_arbiter against a queue-based reference model.
module tb_rasterizer_mem_arbiter;
    localparam int N = 3;
    localparam int AW = 26;
    localparam int MAXO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] outstanding;
    logic       err_orphan;

    rasterizer_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();

    rasterizer_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: owner index (-1 = nobody), last winner, queue of issuing ports.
    int         m_owner, m_last;
    int         m_tags[$];
    logic [N-1:0] m_rdv;
    logic [31:0]  m_rdata;
    logic         m_err;
    int           n_owner, n_last, n_push;
    bit           n_pop;
    logic [N-1:0] n_rdv;
    logic [31:0]  n_rdata;
    logic         n_err;
    logic [N-1:0] c_acc, n_acc;
    bit           c_acc_rd, n_acc_rd;

    function automatic int pick(input logic [N-1:0] e, input int last);
        for (int k = 1; k <= N; k++) begin
            if (e[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_tags.delete();
        m_rdv = '0; m_rdata = '0; m_err = 1'b0;
        c_acc = '0; c_acc_rd = 1'b0;
    endtask

    // Compare process: every cycle, at the falling edge.
    initial begin
        logic [N-1:0] rd, wr, e, exp_wait;
        bit pop, full, fwd, computed;
        int o;
        model_reset();
        forever begin
            @(negedge clock);
            computed = 1'b0;
            if (!reset) begin
                model_reset();
                chk("rst_waitreq", bus.req_waitrequest, 3'b111);
                chk("rst_cmd", {bus.master_read, bus.master_write}, 2'b00);
                chk("rst_rdv", bus.req_readdatavalid, 3'b000);
                chk("rst_outstanding", outstanding, 5'd0);
                chk("rst_err", err_orphan, 1'b0);
            end else begin
                rd = bus.req_read; wr = bus.req_write;
                pop  = bus.master_readdatavalid && m_tags.size() > 0;
                full = (m_tags.size() == MAXO) && !pop;
                for (int i = 0; i < N; i++)
                    e[i] = (rd[i] | wr[i]) && !(rd[i] && !wr[i] && full);
                exp_wait = '1; fwd = 1'b0; o = m_owner;
                if (o >= 0) begin
                    fwd = (rd[o] | wr[o]) && !(rd[o] && full);
                    exp_wait[o] = fwd ? bus.master_waitrequest : 1'b1;
                end
                chk("waitreq", bus.req_waitrequest, exp_wait);
                chk("master_rw", {bus.master_read, bus.master_write},
                    {fwd && rd[o], fwd && wr[o] && !rd[o]});
                if (fwd)
                    chk("master_cmd", {bus.master_address, bus.master_byteenable, bus.master_writedata},
                        {bus.req_address[o], bus.req_byteenable[o], bus.req_writedata[o]});
                chk("rdv", bus.req_readdatavalid, m_rdv);
                if (m_rdv != '0) chk("rdata", bus.req_readdata, m_rdata);
                chk("outstanding", outstanding, m_tags.size());
                chk("err_orphan", err_orphan, m_err);
                n_owner = m_owner; n_last = m_last; n_push = -1; n_acc = '0; n_acc_rd = 1'b0;
                if (o < 0) begin
                    n_owner = pick(e, m_last);
                end else if (fwd && !bus.master_waitrequest) begin
                    n_acc[o] = 1'b1;
                    if (rd[o]) begin n_push = o; n_acc_rd = 1'b1; end
                    n_last = o;
                    e[o] = 1'b0;
                    n_owner = pick(e, o);
                end else if (!(rd[o] | wr[o])) begin
                    n_owner = -1;
                end
                n_pop   = pop;
                n_rdv   = pop ? (N'(1) << m_tags[0]) : '0;
                n_rdata = pop ? bus.master_readdata : m_rdata;
                n_err   = m_err | (bus.master_readdatavalid && m_tags.size() == 0);
                computed = 1'b1;
            end
            @(posedge clock);
            if (computed && reset) begin
                m_owner = n_owner; m_last = n_last;
                if (n_pop) void'(m_tags.pop_front());
                if (n_push >= 0) m_tags.push_back(n_push);
                m_rdv = n_rdv; m_rdata = n_rdata; m_err = n_err;
                c_acc = n_acc; c_acc_rd = n_acc_rd;
            end else begin
                model_reset();
            end
        end
    end

    // Stimulus
    int cyc = 0;
    bit rand_en = 1'b0, sdram_auto = 1'b0;
    int due_q[$];

    task automatic clear_inputs();
        bus.req_read = '0; bus.req_write = '0; bus.req_address = '0;
        bus.req_byteenable = '0; bus.req_writedata = '0;
        bus.master_readdata = 32'h0; bus.master_readdatavalid = 1'b0; bus.master_waitrequest = 1'b0;
    endtask

    task automatic start_cmd(input int i, input bit is_rd, input logic [AW-1:0] a, input logic [31:0] d);
        bus.req_read[i] = is_rd; bus.req_write[i] = !is_rd;
        bus.req_address[i] = a; bus.req_writedata[i] = d;
        bus.req_byteenable[i] = 4'($urandom);
    endtask

    task automatic tick();
        int d;
        @(posedge clock); #1; cyc++;
        for (int i = 0; i < N; i++)
            if (c_acc[i]) begin bus.req_read[i] = 1'b0; bus.req_write[i] = 1'b0; end
        if (rand_en)
            for (int i = 0; i < N; i++)
                if (!(bus.req_read[i] | bus.req_write[i]) && $urandom_range(0, 2) == 0)
                    start_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        if (sdram_auto) begin
            if (c_acc_rd) begin
                d = cyc + $urandom_range(1, ($urandom_range(0, 3) == 0) ? 40 : 6);
                if (due_q.size() > 0 && d < due_q[$]) d = due_q[$];
                due_q.push_back(d);
            end
            bus.master_waitrequest = ($urandom_range(0, 3) == 0);
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                bus.master_readdatavalid = 1'b1; bus.master_readdata = $urandom;
            end else begin
                bus.master_readdatavalid = 1'b0;
            end
        end else begin
            bus.master_readdatavalid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b0; clear_inputs(); due_q.delete(); rand_en = 1'b0; sdram_auto = 1'b0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b1; cyc = 0;
    endtask

    task automatic wait_done(input int i);
        int k = 0;
        while ((bus.req_read[i] | bus.req_write[i]) && k < 30) begin tick(); k++; end
        chk("accept_timeout", 1'(k < 30), 1'b1);
    endtask

    task automatic run_order(input string tag);
        int order[$];
        for (int i = 0; i < N; i++) start_cmd(i, 1'b0, AW'(i * 16), 32'h100 + i);
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (!bus.req_waitrequest[i] && bus.master_write && !bus.master_waitrequest)
                    order.push_back(i + 4 * k);
        end
        while (order.size() < 3) order.push_back(99);
        chk({tag, "_first"}, order[0], 0);
        chk({tag, "_second"}, order[1], 5);
        chk({tag, "_third"}, order[2], 10);
    endtask

    initial begin
        int k;
        clear_inputs();
        #1 reset = 1'b0;

        // Single read on port 1
        do_reset();
        start_cmd(1, 1'b1, 26'h0000100, 32'h0);
        tick();
        chk("t1_read", bus.master_read, 1'b1);
        chk("t1_addr", bus.master_address, 26'h0000100);
        chk("t1_waitreq", bus.req_waitrequest, 3'b101);
        tick();
        chk("t1_idle", bus.master_read, 1'b0);
        chk("t1_outstanding", outstanding, 5'd1);
        repeat (3) tick();
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'hCAFE_0001;
        tick();
        chk("t1_rdv", bus.req_readdatavalid, 3'b010);
        chk("t1_rdata", bus.req_readdata, 32'hCAFE_0001);
        chk("t1_drained", outstanding, 5'd0);

        // Simultaneous requests, twice
        do_reset();
        run_order("t2a");
        run_order("t2b");

        // Stall during port 2 write
        bus.master_waitrequest = 1'b1;
        start_cmd(2, 1'b0, 26'h2ABCDEF, 32'h1234_5678);
        tick();
        start_cmd(0, 1'b0, 26'h0000001, 32'h1);
        for (int s = 0; s < 4; s++) begin
            chk("t3_addr", bus.master_address, 26'h2ABCDEF);
            chk("t3_wdata", bus.master_writedata, 32'h1234_5678);
            chk("t3_waitreq", bus.req_waitrequest, 3'b111);
            tick();
        end
        bus.master_waitrequest = 1'b0; #1;
        chk("t3_release", bus.req_waitrequest, 3'b011);
        tick();
        chk("t3_next_owner", bus.req_waitrequest, 3'b110);
        chk("t3_next_addr", bus.master_address, 26'h0000001);
        wait_done(0);

        // FIFO full with a granted read held
        do_reset();
        for (int n = 0; n < 16; n++) begin
            start_cmd((n % 2) ? 2 : 1, 1'b1, AW'(n * 4), 32'h0);
            if (n == 15) start_cmd(0, 1'b1, 26'h0003F00, 32'h0);
            wait_done((n % 2) ? 2 : 1);
        end
        for (int s = 0; s < 2; s++) begin
            chk("t4_outstanding", outstanding, 5'd16);
            chk("t4_held", bus.master_read, 1'b0);
            chk("t4_waitreq", bus.req_waitrequest, 3'b111);
            tick();
        end
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'hA5A5_0000; #1;
        chk("t4_issue", bus.master_read, 1'b1);
        chk("t4_issue_addr", bus.master_address, 26'h0003F00);
        chk("t4_issue_wait", bus.req_waitrequest, 3'b110);
        tick();
        chk("t4_still_full", outstanding, 5'd16);
        chk("t4_rdv", bus.req_readdatavalid, 3'b010);
        chk("t4_rdata", bus.req_readdata, 32'hA5A5_0000);
        repeat (16) begin
            bus.master_readdatavalid = 1'b1; bus.master_readdata = $urandom;
            tick();
        end
        chk("t4_empty", outstanding, 5'd0);

        // Interleaved reads 0, 2, 0
        start_cmd(0, 1'b1, 26'h10, 32'h0); wait_done(0);
        start_cmd(2, 1'b1, 26'h20, 32'h0); wait_done(2);
        start_cmd(0, 1'b1, 26'h30, 32'h0); wait_done(0);
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'hAAAA_AAAA; tick();
        chk("t5_a_port", bus.req_readdatavalid, 3'b001);
        chk("t5_a_data", bus.req_readdata, 32'hAAAA_AAAA);
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'hBBBB_BBBB; tick();
        chk("t5_b_port", bus.req_readdatavalid, 3'b100);
        chk("t5_b_data", bus.req_readdata, 32'hBBBB_BBBB);
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'hCCCC_CCCC; tick();
        chk("t5_c_port", bus.req_readdatavalid, 3'b001);
        chk("t5_c_data", bus.req_readdata, 32'hCCCC_CCCC);

        // Random traffic
        rand_en = 1'b1; sdram_auto = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        k = 0;
        while (((bus.req_read | bus.req_write) != '0 || due_q.size() > 0 || m_tags.size() > 0) && k < 500) begin
            tick(); k++;
        end
        chk("drain_timeout", 1'(k < 500), 1'b1);
        sdram_auto = 1'b0; bus.master_waitrequest = 1'b0;
        tick();

        // Orphan return
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'hDEAD_BEEF;
        tick();
        chk("t6_err", err_orphan, 1'b1);
        chk("t6_no_rdv", bus.req_readdatavalid, 3'b000);
        repeat (3) tick();
        chk("t6_sticky", err_orphan, 1'b1);

        // Reset in the middle of traffic, then a late return
        rand_en = 1'b1; sdram_auto = 1'b1;
        repeat (40) tick();
        #1 reset = 1'b0;
        #1;
        chk("t7_waitreq", bus.req_waitrequest, 3'b111);
        chk("t7_cmd", {bus.master_read, bus.master_write}, 2'b00);
        chk("t7_addr", bus.master_address, 26'h0);
        chk("t7_rdv", bus.req_readdatavalid, 3'b000);
        chk("t7_rdata", bus.req_readdata, 32'h0);
        chk("t7_outstanding", outstanding, 5'd0);
        chk("t7_err", err_orphan, 1'b0);
        rand_en = 1'b0; sdram_auto = 1'b0; due_q.delete(); clear_inputs();
        @(posedge clock); #1 reset = 1'b1;
        bus.master_readdatavalid = 1'b1; bus.master_readdata = 32'h1;
        tick();
        chk("t7_late_err", err_orphan, 1'b1);
        chk("t7_late_rdv", bus.req_readdatavalid, 3'b000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
